// File: rtl/quad_word_serializer_if.sv
// Handshake bundle for quad_word_serializer: parallel quad capture side and
// serialized single-word stream side.
interface quad_word_serializer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_index;
  logic             out_last;
  logic [CNT_W-1:0] quad_count;

  modport master (
    output a, b, c, d, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_index, out_last, quad_count
  );

  modport slave (
    input  a, b, c, d, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_index, out_last, quad_count
  );
endinterface

// File: rtl/quad_word_serializer.sv
// Captures a four-word quad through a one-deep pending buffer and streams it
// out word by word (a, b, c, d), overlapping capture with serialization.
module quad_word_serializer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic                   clock,
  input logic                   reset_n,
  quad_word_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY        = 2'b00,
    LOADING      = 2'b01,
    SENDING      = 2'b10,
    SENDING_FULL = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] COUNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [WIDTH-1:0] r_pend [4];
  logic [WIDTH-1:0] r_act [4];
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_quadCount;

  logic w_actFull;
  logic w_pendFull;
  logic w_accept;
  logic w_beat;
  logic w_lastBeat;
  logic w_load;

  assign w_actFull  = (r_state == SENDING) || (r_state == SENDING_FULL);
  assign w_pendFull = (r_state == LOADING) || (r_state == SENDING_FULL);
  assign w_accept   = bus.in_valid && !w_pendFull;
  assign w_beat     = w_actFull && bus.out_ready;
  assign w_lastBeat = w_beat && (r_idx == 2'd3);
  // Load and accept are mutually exclusive: one needs pending full, the other empty.
  assign w_load     = w_pendFull && (!w_actFull || w_lastBeat);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= EMPTY;
      r_idx       <= 2'd0;
      r_quadCount <= '0;
      for (int i = 0; i < 4; i++) begin
        r_pend[i] <= '0;
        r_act[i]  <= '0;
      end
    end else begin
      case (r_state)
        EMPTY:        if (w_accept) r_state <= LOADING;
        LOADING:      r_state <= SENDING;
        SENDING: begin
          if (w_lastBeat)    r_state <= w_accept ? LOADING : EMPTY;
          else if (w_accept) r_state <= SENDING_FULL;
        end
        SENDING_FULL: if (w_lastBeat) r_state <= SENDING;
        default:      r_state <= EMPTY;
      endcase

      if (w_accept) begin
        r_pend[0] <= bus.a;
        r_pend[1] <= bus.b;
        r_pend[2] <= bus.c;
        r_pend[3] <= bus.d;
      end

      // The last beat wraps idx back to 0, so an idle stream always reports index 0.
      if (w_load) begin
        for (int i = 0; i < 4; i++) r_act[i] <= r_pend[i];
        r_idx <= 2'd0;
      end else if (w_beat) begin
        r_idx <= r_idx + 2'd1;
      end

      if (w_lastBeat) r_quadCount <= r_quadCount + COUNT_ONE;
    end
  end

  assign bus.in_ready   = !w_pendFull;
  assign bus.out_valid  = w_actFull;
  assign bus.out_data   = r_act[r_idx];
  assign bus.out_index  = r_idx;
  assign bus.out_last   = w_actFull && (r_idx == 2'd3);
  assign bus.quad_count = r_quadCount;

endmodule

// File: tb/tb_quad_word_serializer.sv
// Self-checking bench: directed and random traffic against a queue-based model
// of the pending slot and the word stream; a CNT_W=2 copy shows counter wrap.
module tb_quad_word_serializer;

  logic clock = 1'b0;
  logic reset_n;

  int errorCount = 0;
  int checkCount = 0;

  quad_word_serializer_if #(.WIDTH(32), .CNT_W(16)) busMain ();
  quad_word_serializer_if #(.WIDTH(32), .CNT_W(2))  busWrap ();

  quad_word_serializer #(.WIDTH(32), .CNT_W(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (busMain)
  );

  quad_word_serializer #(.WIDTH(32), .CNT_W(2)) dutWrap (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (busWrap)
  );

  always #5 clock = ~clock;

  // Model: a quad waiting to be serialized, the words still to be sent, and
  // the number of quads fully emitted.
  logic [31:0] mPend[$];
  logic [31:0] mAct[$];
  int unsigned mDone;
  bit          mAccepted;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("in_ready",  64'(busMain.in_ready),  64'(mPend.size() == 0));
    checkOutput("out_valid", 64'(busMain.out_valid), 64'(mAct.size() > 0));
    checkOutput("out_index", 64'(busMain.out_index), 64'((4 - mAct.size()) % 4));
    checkOutput("out_last",  64'(busMain.out_last),  64'(mAct.size() == 1));
    if (mAct.size() > 0) checkOutput("out_data", 64'(busMain.out_data), 64'(mAct[0]));
    checkOutput("quad_count", 64'(busMain.quad_count), 64'(mDone % 65536));
    checkOutput("wrap_valid", 64'(busWrap.out_valid),  64'(mAct.size() > 0));
    checkOutput("wrap_count", 64'(busWrap.quad_count), 64'(mDone % 4));
  endtask

  task automatic driveInputs(input logic v, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] c, input logic [31:0] d, input logic rdy);
    busMain.in_valid = v;  busWrap.in_valid = v;
    busMain.a = a;  busMain.b = b;  busMain.c = c;  busMain.d = d;
    busWrap.a = a;  busWrap.b = b;  busWrap.c = c;  busWrap.d = d;
    busMain.out_ready = rdy;  busWrap.out_ready = rdy;
  endtask

  // Called at a falling edge: check, drive, advance the model across the next rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] d, input logic rdy);
    bit hadAct;
    bit lastBeat;
    bit accept;
    checkAll();
    driveInputs(v, a, b, c, d, rdy);
    hadAct   = mAct.size() > 0;
    lastBeat = hadAct && rdy && (mAct.size() == 1);
    accept   = v && (mPend.size() == 0);
    if (hadAct && rdy) mAct.delete(0);
    if (lastBeat) mDone++;
    if (mPend.size() > 0 && (!hadAct || lastBeat)) begin
      mAct = mPend;
      mPend.delete();
    end
    if (accept) mPend = '{a, b, c, d};
    mAccepted = accept;
    @(negedge clock);
  endtask

  task automatic pushQuad(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d, input logic rdy);
    int tries;
    tries = 0;
    mAccepted = 1'b0;
    while (!mAccepted && tries < 50) begin
      applyStimulus(1'b1, a, b, c, d, rdy);
      tries++;
    end
    if (!mAccepted) checkOutput("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, rdy);
  endtask

  // Asynchronous reset in mid-cycle: outputs must clear without waiting for an edge.
  task automatic applyReset();
    driveInputs(1'b0, '0, '0, '0, '0, 1'b0);
    #2 reset_n = 1'b0;
    mPend.delete();
    mAct.delete();
    mDone = 0;
    #1 checkAll();
    checkOutput("rst_out_data", 64'(busMain.out_data), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int steps;
    mDone = 0;
    reset_n = 1'b0;
    driveInputs(1'b0, '0, '0, '0, '0, 1'b0);
    #1 checkAll();
    checkOutput("rst_out_data", 64'(busMain.out_data), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] single quad");
    pushQuad(32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
    idle(7, 1'b1);

    $display("[TB] back-to-back quads");
    pushQuad(32'd10, 32'd11, 32'd12, 32'd13, 1'b1);
    pushQuad(32'd20, 32'd21, 32'd22, 32'd23, 1'b1);
    idle(10, 1'b1);

    $display("[TB] backpressure");
    pushQuad(32'd5, 32'd6, 32'd7, 32'd8, 1'b1);
    idle(2, 1'b1);
    idle(3, 1'b0);
    idle(5, 1'b1);

    $display("[TB] full buffer");
    pushQuad(32'hA0, 32'hA1, 32'hA2, 32'hA3, 1'b0);
    idle(1, 1'b0);
    pushQuad(32'hB0, 32'hB1, 32'hB2, 32'hB3, 1'b0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, $urandom, $urandom, $urandom, $urandom, 1'b0);
    idle(12, 1'b1);

    $display("[TB] reset mid-stream");
    pushQuad(32'd31, 32'd32, 32'd33, 32'd34, 1'b1);
    steps = 0;
    while (mAct.size() != 2 && steps < 20) begin
      idle(1, 1'b1);
      steps++;
    end
    if (mAct.size() != 2) checkOutput("mid_reset_timeout", 64'd0, 64'd1);
    applyReset();
    idle(6, 1'b1);

    $display("[TB] counter wrap");
    for (int q = 0; q < 5; q++)
      pushQuad(32'(100 + 4*q), 32'(101 + 4*q), 32'(102 + 4*q), 32'(103 + 4*q), 1'b1);
    idle(10, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, $urandom,
                    (i >= 1000 && i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    idle(12, 1'b1);
    checkAll();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
